// File: rtl/frame_reader_pkg.sv
// Shared video constants: screen geometry, zoom encodings, default background colour.
package frame_reader_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned PIX_W    = 8;

    typedef enum logic [1:0] {
        ZOOM_X1   = 2'd0,
        ZOOM_X2   = 2'd1,
        ZOOM_X4   = 2'd2,
        ZOOM_RSVD = 2'd3
    } zoom_e;

    localparam logic [PIX_W-1:0] BG_COLOR_DEFAULT = 8'h00;

endpackage

// File: rtl/delay_line.sv
// Parameterised shift-register delay with asynchronous clear.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift din through DEPTH registers; reset empties the line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/frame_reader.sv
// Centred, zoomable image window: maps screen coordinates to image-RAM fetches
// and aligns returned pixel data with the VGA colour output.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int unsigned      IMG_W    = 160,
    parameter int unsigned      IMG_H    = 120,
    parameter int unsigned      MEM_LAT  = 2,
    parameter logic [PIX_W-1:0] BG_COLOR = BG_COLOR_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   next_x,
    input  logic [COORD_W-1:0]   next_y,
    input  logic                 blank,
    input  logic                 vsync,
    input  logic [1:0]           zoom_sel,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [PIX_W-1:0]     color_out,
    output logic                 zoom_err
);

    localparam int unsigned BND_W = COORD_W + 1;

    // Window origin for each zoom level (image centred on screen).
    localparam int unsigned X0_Z0 = (SCREEN_W - IMG_W) / 2;
    localparam int unsigned X0_Z1 = (SCREEN_W - 2 * IMG_W) / 2;
    localparam int unsigned X0_Z2 = (SCREEN_W - 4 * IMG_W) / 2;
    localparam int unsigned Y0_Z0 = (SCREEN_H - IMG_H) / 2;
    localparam int unsigned Y0_Z1 = (SCREEN_H - 2 * IMG_H) / 2;
    localparam int unsigned Y0_Z2 = (SCREEN_H - 4 * IMG_H) / 2;

    localparam logic [ADDR_W-1:0] IMG_W_BITS = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = ADDR_W'(IMG_W * IMG_H - 1);

    // Row base sy*IMG_W as a shift-add over the constant's set bits.
    function automatic logic [ADDR_W-1:0] row_base(input logic [COORD_W-1:0] sy);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            if (IMG_W_BITS[i]) begin
                acc = acc + (ADDR_W'(sy) << i);
            end
        end
        return acc;
    endfunction

    zoom_e              z;
    logic               vsync_q;
    logic               vsync_fall_c;
    logic [1:0]         zshift_c;
    logic [BND_W-1:0]   x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic [BND_W-1:0]   px_c, py_c, dx_c, dy_c;
    logic [COORD_W-1:0] sx_c, sy_c;
    logic               in_win_c;
    logic [ADDR_W-1:0]  addr_c;
    logic               flag_d;

    assign vsync_fall_c = vsync_q & ~vsync;

    // Previous-cycle vsync for falling-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    // Latch the requested zoom once per frame; reserved code falls back to x1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            z        <= ZOOM_X1;
            zoom_err <= 1'b0;
        end else if (vsync_fall_c) begin
            if (zoom_e'(zoom_sel) == ZOOM_RSVD) begin
                z        <= ZOOM_X1;
                zoom_err <= 1'b1;
            end else begin
                z        <= zoom_e'(zoom_sel);
                zoom_err <= 1'b0;
            end
        end
    end

    // Window bounds (inclusive) and source coordinates for the active zoom.
    always_comb begin
        zshift_c = 2'd0;
        x_lo_c   = BND_W'(X0_Z0);
        x_hi_c   = BND_W'(X0_Z0 + IMG_W - 1);
        y_lo_c   = BND_W'(Y0_Z0);
        y_hi_c   = BND_W'(Y0_Z0 + IMG_H - 1);
        case (z)
            ZOOM_X2: begin
                zshift_c = 2'd1;
                x_lo_c   = BND_W'(X0_Z1);
                x_hi_c   = BND_W'(X0_Z1 + 2 * IMG_W - 1);
                y_lo_c   = BND_W'(Y0_Z1);
                y_hi_c   = BND_W'(Y0_Z1 + 2 * IMG_H - 1);
            end
            ZOOM_X4: begin
                zshift_c = 2'd2;
                x_lo_c   = BND_W'(X0_Z2);
                x_hi_c   = BND_W'(X0_Z2 + 4 * IMG_W - 1);
                y_lo_c   = BND_W'(Y0_Z2);
                y_hi_c   = BND_W'(Y0_Z2 + 4 * IMG_H - 1);
            end
            default: ;
        endcase

        px_c = BND_W'(next_x);
        py_c = BND_W'(next_y);
        in_win_c = blank
                 && (px_c >= x_lo_c) && (px_c <= x_hi_c)
                 && (py_c >= y_lo_c) && (py_c <= y_hi_c);

        dx_c = px_c - x_lo_c;
        dy_c = py_c - y_lo_c;
        sx_c = COORD_W'(dx_c >> zshift_c);
        sy_c = COORD_W'(dy_c >> zshift_c);

        addr_c = row_base(sy_c) + ADDR_W'(sx_c);
        if (addr_c > ADDR_MAX) begin
            addr_c = ADDR_MAX;
        end
    end

    // Stage 1: issue the RAM fetch; address holds when no fetch is made.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
        end else begin
            mem_rd <= in_win_c;
            if (in_win_c) begin
                mem_addr <= addr_c;
            end
        end
    end

    // In-window flag travels alongside the RAM read latency.
    delay_line #(
        .WIDTH (1),
        .DEPTH (MEM_LAT)
    ) u_flag_dly (
        .clock (clock),
        .reset (reset),
        .din   (mem_rd),
        .dout  (flag_d)
    );

    // Output colour: RAM data inside the window, background elsewhere.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            color_out <= BG_COLOR;
        end else begin
            color_out <= flag_d ? mem_rdata : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader with a fixed-latency RAM returning addr[7:0].
module tb_frame_reader;

    localparam int unsigned MEM_LAT = 2;

    logic        clock;
    logic        reset;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic        blank;
    logic        vsync;
    logic [1:0]  zoom_sel;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [7:0]  color_out;
    logic        zoom_err;

    int total;
    int bad;

    logic [7:0] ram_pipe [MEM_LAT];

    frame_reader #(
        .IMG_W    (160),
        .IMG_H    (120),
        .MEM_LAT  (MEM_LAT),
        .BG_COLOR (8'h00)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .next_x    (next_x),
        .next_y    (next_y),
        .blank     (blank),
        .vsync     (vsync),
        .zoom_sel  (zoom_sel),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .color_out (color_out),
        .zoom_err  (zoom_err)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    // RAM model: data = addr[7:0], valid MEM_LAT clocks after the address.
    always @(posedge clock) begin
        ram_pipe[0] <= mem_addr[7:0];
        for (int i = 1; i < int'(MEM_LAT); i++) begin
            ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign mem_rdata = ram_pipe[MEM_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Latch a zoom request with one vsync pulse low.
    task automatic set_zoom(input logic [1:0] sel);
        @(negedge clock);
        zoom_sel = sel;
        vsync    = 1'b0;
        @(negedge clock);
        vsync    = 1'b1;
        @(negedge clock);
    endtask

    // Present one pixel, then idle; check fetch after 1 clock and colour after MEM_LAT+2.
    task automatic pix(input string tag, input int x, input int y, input logic b,
                       input logic exp_rd, input int exp_addr);
        logic [14:0] a;
        a = 15'(exp_addr);
        @(negedge clock);
        next_x = 10'(x);
        next_y = 10'(y);
        blank  = b;
        @(negedge clock);
        chk({tag, ".rd"}, 32'(mem_rd), 32'(exp_rd));
        if (exp_rd) chk({tag, ".addr"}, 32'(mem_addr), 32'(a));
        blank  = 1'b0;
        next_x = '0;
        next_y = '0;
        @(negedge clock);
        @(negedge clock);
        chk({tag, ".early"}, 32'(color_out), 32'h00);
        @(negedge clock);
        chk({tag, ".color"}, 32'(color_out), exp_rd ? 32'(a[7:0]) : 32'h00);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        next_x   = '0;
        next_y   = '0;
        blank    = 1'b0;
        vsync    = 1'b1;
        zoom_sel = 2'd0;

        #5;
        chk("rst.addr", 32'(mem_addr), 32'h0);
        chk("rst.rd", 32'(mem_rd), 32'h0);
        chk("rst.color", 32'(color_out), 32'h00);
        chk("rst.zerr", 32'(zoom_err), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // x1: window x 240..399, y 180..299
        pix("z0_origin", 240, 180, 1'b1, 1'b1, 0);
        pix("z0_last",   399, 299, 1'b1, 1'b1, 19199);
        pix("z0_left",   239, 180, 1'b1, 1'b0, 0);
        pix("z0_lat",    245, 180, 1'b1, 1'b1, 5);
        pix("z0_right",  400, 180, 1'b1, 1'b0, 0);
        pix("z0_botrow", 240, 299, 1'b1, 1'b1, 19040);
        pix("z0_below",  240, 300, 1'b1, 1'b0, 0);
        pix("z0_blank",  245, 180, 1'b0, 1'b0, 0);

        // zoom request without a vsync fall has no effect
        @(negedge clock);
        zoom_sel = 2'd1;
        pix("hold_z0_out", 160, 120, 1'b1, 1'b0, 0);
        pix("hold_z0_in",  240, 180, 1'b1, 1'b1, 0);
        set_zoom(2'd1);
        chk("z1.zerr", 32'(zoom_err), 32'h0);

        // x2: window x 160..479, y 120..359
        pix("z1_origin", 160, 120, 1'b1, 1'b1, 0);
        pix("z1_dup",    161, 121, 1'b1, 1'b1, 0);
        pix("z1_next",   162, 120, 1'b1, 1'b1, 1);
        pix("z1_right",  480, 120, 1'b1, 1'b0, 0);
        pix("z1_last",   479, 359, 1'b1, 1'b1, 19199);

        // reserved zoom falls back to x1 and flags an error
        set_zoom(2'd3);
        chk("rsvd.zerr", 32'(zoom_err), 32'h1);
        pix("rsvd_x1_in",  240, 180, 1'b1, 1'b1, 0);
        pix("rsvd_x1_out", 160, 120, 1'b1, 1'b0, 0);

        // x4: whole active area
        set_zoom(2'd2);
        chk("z2.zerr", 32'(zoom_err), 32'h0);
        pix("z2_origin", 0, 0, 1'b1, 1'b1, 0);
        pix("z2_last",   639, 479, 1'b1, 1'b1, 19199);
        pix("z2_dup",    3, 3, 1'b1, 1'b1, 0);
        pix("z2_step",   4, 4, 1'b1, 1'b1, 161);
        pix("z2_xover",  640, 0, 1'b1, 1'b0, 0);
        pix("z2_yover",  0, 480, 1'b1, 1'b0, 0);

        // reset mid-line with a full pipeline at x4
        @(negedge clock);
        next_x = 10'd245;
        next_y = 10'd180;
        blank  = 1'b1;
        repeat (5) @(negedge clock);
        chk("pre_rst.rd", 32'(mem_rd), 32'h1);
        chk("pre_rst.color", 32'(color_out), 32'h5D);
        #10;
        reset = 1'b0;
        #1;
        chk("mid_rst.addr", 32'(mem_addr), 32'h0);
        chk("mid_rst.rd", 32'(mem_rd), 32'h0);
        chk("mid_rst.color", 32'(color_out), 32'h00);
        chk("mid_rst.zerr", 32'(zoom_err), 32'h0);
        @(negedge clock);
        chk("in_rst.rd", 32'(mem_rd), 32'h0);
        reset  = 1'b1;
        blank  = 1'b0;
        next_x = '0;
        next_y = '0;
        @(negedge clock);
        chk("post_rst.rd", 32'(mem_rd), 32'h0);
        chk("post_rst.color", 32'(color_out), 32'h00);
        // z returned to x1 by reset: (245,180) -> addr 5
        pix("post_rst_first", 245, 180, 1'b1, 1'b1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
